uart_tx_arbiter: RTL and testbench

//   Shares the single UART TX byte path between NUM_REQ byte-stream requesters
//   (e.g. RX->TX loopback FIFO, CORE debug/console output). Round-robin grant,

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte path between NUM_REQ
// valid/ready byte streams. A grant is held for a whole burst and ends on
// req_last, after MAX_BURST beats, or after IDLE_TIMEOUT cycles with no data
// from the grant holder. There is always one IDLE cycle between bursts.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [DATA_W-1:0]          tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic                       burst_cut_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [GW-1:0] RR_INIT   = GW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          burst_cut_q, burst_cut_d;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] cand;
  logic          xfer;
  logic          holder_valid;

  // Round-robin pick: first valid requester after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state, counters and the combinational TX/ready datapath.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    burst_cut_d  = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = '0;
    req_ready_o  = '0;
    xfer         = 1'b0;
    holder_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Grant is registered here; data starts flowing next cycle.
        if (pick_valid) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = S_STREAM;
        end
      end

      S_STREAM: begin
        holder_valid         = req_valid_i[grant_q];
        tx_valid_o           = holder_valid;
        tx_data_o            = req_data_i[grant_q*DATA_W +: DATA_W];
        req_ready_o[grant_q] = tx_ready_i;
        xfer                 = holder_valid & tx_ready_i;

        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        idle_cnt_d = holder_valid ? '0 : idle_cnt_q + 1'b1;

        // Release priority: req_last beats a full burst beats a timeout,
        // and only the forced releases raise burst_cut.
        if (xfer && req_last_i[grant_q]) begin
          state_d = S_IDLE;
        end else if (xfer && (beat_cnt_d == BEAT_MAX)) begin
          state_d     = S_IDLE;
          burst_cut_d = 1'b1;
        end else if (idle_cnt_d == IDLE_MAX) begin
          state_d     = S_IDLE;
          burst_cut_d = 1'b1;
        end

        if (state_d == S_IDLE) begin
          rr_ptr_d   = grant_q;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any byte in flight and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= RR_INIT;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      burst_cut_q <= burst_cut_d;
    end
  end

  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q == S_STREAM);
  assign burst_cut_o = burst_cut_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle model of the arbitration
// rules is compared against the DUT every cycle, and directed scenarios pin
// grant order, burst lengths and cut pulses to hand-computed literals.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [0:0]      grant_id;
  logic            busy;
  logic            burst_cut;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .grant_id_o(grant_id), .busy_o(busy),
    .burst_cut_o(burst_cut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester sources ({last, data} per entry) -------------
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [N-1:0] acc = '0;
  logic [8:0] dump;

  task automatic drive_inputs();
    logic [8:0] e;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    if (q0.size() > 0) begin
      e = q0[0];
      req_valid[0] = 1'b1; req_last[0] = e[8]; req_data[7:0] = e[7:0];
    end
    if (q1.size() > 0) begin
      e = q1[0];
      req_valid[1] = 1'b1; req_last[1] = e[8]; req_data[15:8] = e[7:0];
    end
  endtask

  // grp = bytes per burst (last on every grp-th byte); 0 = never last.
  task automatic load(input int which, input int n, input logic [7:0] base, input int grp);
    logic [8:0] e;
    for (int k = 0; k < n; k++) begin
      e[7:0] = base + 8'(k);
      e[8]   = (grp != 0) && ((k % grp) == grp - 1);
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
    drive_inputs();
  endtask

  // Pop accepted bytes just after each edge, then present the next front.
  initial forever begin
    @(posedge clk);
    #1;
    if (acc[0]) dump = q0.pop_front();
    if (acc[1]) dump = q1.pop_front();
    drive_inputs();
  end

  // ---------------- behavioural model --------------------------------------
  int m_holder = -1;   // requester currently streaming, -1 when idle
  int m_ptr    = N - 1;
  int m_gid    = 0;
  int m_beats  = 0;
  int m_idle   = 0;
  bit m_cut    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holder = -1; m_ptr = N - 1; m_gid = 0; m_beats = 0; m_idle = 0; m_cut = 1'b0;
    end else begin
      bit took, rel, cut, found;
      m_cut = 1'b0;
      if (m_holder < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!found && req_valid[c]) begin
            found = 1'b1; m_holder = c; m_gid = c; m_beats = 0; m_idle = 0;
          end
        end
      end else begin
        took = req_valid[m_holder] && tx_ready;
        if (took) m_beats = m_beats + 1;
        m_idle = req_valid[m_holder] ? 0 : m_idle + 1;
        rel = 1'b0; cut = 1'b0;
        if (took && req_last[m_holder]) rel = 1'b1;
        else if (took && m_beats == MB) begin rel = 1'b1; cut = 1'b1; end
        else if (m_idle == IT) begin rel = 1'b1; cut = 1'b1; end
        if (rel) begin
          m_ptr = m_holder; m_holder = -1; m_beats = 0; m_idle = 0; m_cut = cut;
        end
      end
    end
  end

  // ---------------- per-cycle compare and observation logs -----------------
  int glog[$];        // grant_id at each burst start
  int blog[$];        // transfers per burst
  int cut_cnt = 0;
  int idle_stream = 0;
  int cur_len = 0;
  bit prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    acc = req_valid & req_ready;
    if (!rst_n) begin
      prev_busy = 1'b0;
      cur_len   = 0;
    end else begin
      logic [N-1:0]  e_ready;
      logic [DW-1:0] e_data;
      logic          e_valid;
      e_ready = '0; e_data = '0; e_valid = 1'b0;
      if (m_holder >= 0) begin
        e_valid          = req_valid[m_holder];
        e_data           = req_data[m_holder*DW +: DW];
        e_ready[m_holder] = tx_ready;
      end
      check("cyc_busy", 32'(busy), 32'(m_holder >= 0));
      check("cyc_grant_id", 32'(grant_id), 32'(m_gid));
      check("cyc_burst_cut", 32'(burst_cut), 32'(m_cut));
      check("cyc_tx_valid", 32'(tx_valid), 32'(e_valid));
      check("cyc_tx_data", 32'(tx_data), 32'(e_data));
      check("cyc_req_ready", 32'(req_ready), 32'(e_ready));

      if (busy && !prev_busy) glog.push_back(int'(grant_id));
      if (tx_valid && tx_ready) cur_len++;
      if (!busy && prev_busy) begin blog.push_back(cur_len); cur_len = 0; end
      if (burst_cut) cut_cnt++;
      if (busy && !tx_valid) idle_stream++;
      prev_busy = busy;
    end
  end

  task automatic clear_logs();
    glog.delete(); blog.delete(); cut_cnt = 0; idle_stream = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !busy) && n < budget);
    check({name, "_completes"}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < budget);
    check({name, "_granted"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios --------------------------------------
  initial begin
    // 1: reset state, then alternating 3-byte bursts from both requesters.
    #1 rst_n = 1'b0;
    #2;
    load(0, 9, 8'h00, 3);
    load(1, 9, 8'h80, 3);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_burst_cut", 32'(burst_cut), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    wait_done("t1", 200);
    check("t1_bursts", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t1_grant_order", 32'(glog[i]), 32'(i % 2));
      check("t1_burst_len", 32'(blog[i]), 32'd3);
    end
    check("t1_cuts", 32'(cut_cnt), 32'd0);

    // 2: 20-byte stream from req0 is cut at 16, req1 served, req0 resumes.
    clear_logs();
    @(posedge clk); #2;
    load(0, 20, 8'h10, 20);
    load(1, 2, 8'hA0, 2);
    wait_done("t2", 200);
    check("t2_bursts", 32'(glog.size()), 32'd3);
    check("t2_grant0", 32'(glog[0]), 32'd0);
    check("t2_grant1", 32'(glog[1]), 32'd1);
    check("t2_grant2", 32'(glog[2]), 32'd0);
    check("t2_len0", 32'(blog[0]), 32'd16);
    check("t2_len1", 32'(blog[1]), 32'd2);
    check("t2_len2", 32'(blog[2]), 32'd4);
    check("t2_cuts", 32'(cut_cnt), 32'd1);

    // 3: tx_ready low for 10 cycles mid-burst freezes the third byte.
    clear_logs();
    @(posedge clk); #2;
    load(0, 6, 8'h40, 6);
    wait_busy("t3", 10);
    @(posedge clk);
    @(posedge clk);
    #2 tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_stall_valid", 32'(tx_valid), 32'd1);
      check("t3_stall_data", 32'(tx_data), 32'h42);
      check("t3_stall_ready", 32'(req_ready), 32'd0);
      check("t3_stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #2 tx_ready = 1'b1;
    wait_done("t3", 100);
    check("t3_len", 32'(blog[0]), 32'd6);
    check("t3_cuts", 32'(cut_cnt), 32'd0);

    // 4: holder runs dry without req_last; timeout after 4 empty cycles.
    clear_logs();
    @(posedge clk); #2;
    load(0, 3, 8'h60, 0);
    wait_done("t4", 100);
    check("t4_len", 32'(blog[0]), 32'd3);
    check("t4_idle_cycles", 32'(idle_stream), 32'd4);
    check("t4_cuts", 32'(cut_cnt), 32'd1);
    check("t4_grant_kept", 32'(grant_id), 32'd0);

    // 5: req_last on the 16th beat releases without a cut pulse.
    clear_logs();
    @(posedge clk); #2;
    load(0, 16, 8'h70, 16);
    wait_done("t5", 100);
    check("t5_len", 32'(blog[0]), 32'd16);
    check("t5_cuts", 32'(cut_cnt), 32'd0);

    // 6: reset during req1's burst; afterwards req0 is picked first again.
    clear_logs();
    @(posedge clk); #2;
    load(0, 10, 8'hC0, 10);
    load(1, 10, 8'hD0, 10);
    wait_busy("t6", 10);
    check("t6_first_grant", 32'(grant_id), 32'd1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    clear_logs();
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    wait_done("t6", 200);
    check("t6_bursts", 32'(glog.size()), 32'd2);
    check("t6_grant0", 32'(glog[0]), 32'd0);
    check("t6_grant1", 32'(glog[1]), 32'd1);
    check("t6_len0", 32'(blog[0]), 32'd10);
    check("t6_len1", 32'(blog[1]), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
